// File: rtl/mem_access_stage_if.sv
// -----------------------------------------------------------------------------
// mem_access_stage_if
// Byte-wide request/acknowledge memory port used by the MEM stage.
//   mem_req   : byte transfer request (stage -> memory)
//   mem_we    : 1 = write, 0 = read, valid while mem_req = 1
//   mem_addr  : byte address, valid while mem_req = 1
//   mem_wdata : write byte, valid while mem_req = 1
//   mem_rdata : read byte (memory -> stage), valid when mem_ack = 1
//   mem_ack   : one-cycle pulse completing the current byte transfer
// master = pipeline stage side, slave = memory side.
// -----------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// -----------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the RV32I pipeline. Loads and stores are sequenced one byte per
// transfer over a req/ack memory port; busy_line stalls the upstream pipeline
// registers while an access is in flight. Non-memory ops pass straight through
// with one cycle of latency.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   opcode_in[10:0]     : [6:0] major opcode, [9:7] funct3, [10] unused
//   data_in[31:0]       : ALU result / effective address
//   scrdata_in[31:0]    : store source data (rs2)
//   Rd_in[4:0]          : destination register
//   busy_line           : stall request to upstream registers
//   mem                 : byte memory port (master side)
//   opcode_out, data_out, Rd_out : registered result to MEM/WB
// -----------------------------------------------------------------------------
module mem_access_stage #(
    parameter int OPCODE_W = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode_in,
    input  logic [31:0]         data_in,
    input  logic [31:0]         scrdata_in,
    input  logic [4:0]          Rd_in,
    output logic                busy_line,
    mem_access_stage_if.master  mem,
    output logic [OPCODE_W-1:0] opcode_out,
    output logic [31:0]         data_out,
    output logic [4:0]          Rd_out
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                state;
    logic [1:0]            idx;
    logic [31:0]           base_q;
    logic [2:0]            f3_q;
    logic [3:0][7:0]       sdata_q;
    logic [3:0][7:0]       rbuf_q;
    logic [OPCODE_W-1:0]   op_q;
    logic [4:0]            rd_q;

    logic is_mem_in;
    logic is_store_q;

    // Index of the final byte: funct3[1:0] 00 -> 1 byte, 01 -> 2, 10/11 -> 4.
    function automatic logic [1:0] last_index(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   last_index = 2'd0;
            2'b01:   last_index = 2'd1;
            default: last_index = 2'd3;
        endcase
    endfunction

    // Load result formatting; unlisted funct3 codes return the full word.
    function automatic logic [31:0] load_extend(input logic [2:0] f3,
                                                input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] r;
        b = w[7:0];
        h = w[15:0];
        case (f3)
            3'b000:  r = 32'(b);
            3'b001:  r = 32'(h);
            3'b100:  r = {24'b0, w[7:0]};
            3'b101:  r = {16'b0, w[15:0]};
            default: r = w;
        endcase
        load_extend = $unsigned(r);
    endfunction

    assign is_mem_in  = (opcode_in[6:0] == OP_LOAD) || (opcode_in[6:0] == OP_STORE);
    assign is_store_q = (op_q[6:0] == OP_STORE);

    // busy must rise in the same cycle a memory op is presented so the
    // upstream registers hold it on the very next edge.
    assign busy_line     = (state == ACCESS) || ((state == IDLE) && is_mem_in);
    assign mem.mem_req   = (state == ACCESS);
    assign mem.mem_we    = (state == ACCESS) && is_store_q;
    assign mem.mem_addr  = base_q + {30'b0, idx};
    assign mem.mem_wdata = sdata_q[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= 2'd0;
            opcode_out <= '0;
            data_out   <= '0;
            Rd_out     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_mem_in) begin
                        base_q     <= data_in;
                        f3_q       <= opcode_in[9:7];
                        sdata_q    <= scrdata_in;
                        op_q       <= opcode_in;
                        rd_q       <= Rd_in;
                        idx        <= 2'd0;
                        state      <= ACCESS;
                        opcode_out <= '0;
                        data_out   <= '0;
                        Rd_out     <= '0;
                    end else begin
                        opcode_out <= opcode_in;
                        data_out   <= data_in;
                        Rd_out     <= Rd_in;
                    end
                end
                ACCESS: begin
                    if (mem.mem_ack) begin
                        if (!is_store_q) begin
                            rbuf_q[idx] <= mem.mem_rdata;
                        end
                        if (idx == last_index(f3_q)) begin
                            state <= DONE;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                DONE: begin
                    opcode_out <= op_q;
                    Rd_out     <= rd_q;
                    data_out   <= is_store_q ? base_q : load_extend(f3_q, rbuf_q);
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the RISC-V pipeline. It sits downstream of the EX/MEM pipeline register and consumes that register's opcode, ALU result, store data and Rd outputs.
- Performs loads and stores through a byte-wide request/acknowledge memory port. Multi-byte accesses are sequenced one byte per transfer.
- Drives busy_line back to stall the upstream pipeline registers while an access is in flight.
- Presents a registered result (opcode, data, Rd) to the MEM/WB register.

Parameters:
- OPCODE_W, 11, width of opcode bus. Bits [6:0] = RV32I major opcode, [9:7] = funct3, [10] ignored.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- opcode_in  input  11  opcode from EX/MEM register
- data_in  input  32  ALU result; the effective address for loads/stores
- scrdata_in  input  32  store source data (rs2)
- Rd_in  input  5  destination register
- busy_line  output  1  stall request to upstream pipeline registers
- mem_req  output  1  byte transfer request
- mem_we  output  1  1 = write, 0 = read; valid while mem_req = 1
- mem_addr  output  32  byte address; valid while mem_req = 1
- mem_wdata  output  8  write byte; valid while mem_req = 1
- mem_rdata  input  8  read byte; valid when mem_ack = 1
- mem_ack  input  1  one-cycle pulse; completes the current byte transfer
- opcode_out  output  11  to MEM/WB register
- data_out  output  32  load result, or pass-through ALU result
- Rd_out  output  5  to MEM/WB register

Behaviour:
- Reset is synchronous and active-high (rst); one clock (clk).
- On rst: state = IDLE, byte index = 0, opcode_out = 0, data_out = 0, Rd_out = 0. mem_req, mem_we and busy_line go low once the reset edge has been taken.
- States: IDLE, ACCESS, DONE.
- Memory op: opcode_in[6:0] = 7'b0000011 (load) or 7'b0100011 (store).
- Byte count N from funct3[1:0]: 00 → 1, 01 → 2, 10 → 4. funct3[1:0] = 11 is treated as N = 4.
- IDLE, non-memory op (includes opcode 0 bubble):
  - Outputs register the inputs unchanged next edge (1-cycle latency).
  - busy_line = 0.
- IDLE, memory op:
  - busy_line = 1 combinationally in the same cycle.
  - At the edge: latch base address, funct3, scrdata_in, opcode_in and Rd_in; set index = 0; go to ACCESS.
  - Outputs become a bubble: opcode_out = 0, Rd_out = 0, data_out = 0.
- ACCESS:
  - busy_line = 1, mem_req = 1.
  - mem_addr = base + index (32-bit wrap-around).
  - mem_we = 1 for a store; mem_wdata = latched store data byte[index] (little-endian).
  - Bubble outputs are held.
  - On mem_ack:
    - For a load, capture mem_rdata into result byte[index].
    - If index = N−1, go to DONE; otherwise index + 1.
    - mem_addr and mem_wdata update in the cycle after the ack.
  - mem_req stays high between bytes; there is no gap cycle.
  - No ack: wait indefinitely; there is no timeout.
- DONE:
  - busy_line = 0, mem_req = 0.
  - At the edge: opcode_out = latched opcode, Rd_out = latched Rd; go to IDLE.
  - Load data_out by funct3: LB 000 sign-extend byte; LH 001 sign-extend half; LW 010 word; LBU 100 zero-extend byte; LHU 101 zero-extend half.
  - Store data_out = base address.
  - Because busy_line is low in DONE, the EX/MEM register loads the next instruction on the same edge.
- No alignment check: a misaligned access is simply N sequential bytes.
- mem_ack seen in IDLE or DONE is ignored.
- rst asserted during ACCESS:
  - Aborts at that edge; partial store bytes already acked are not undone.
  - A late ack arriving after reset is ignored.
- Timing with mem_ack returned combinationally in the first ACCESS cycle and every ACCESS cycle:
  - LW: busy_line high 5 cycles (IDLE + 4 ACCESS), result on outputs 6 edges after presentation.
  - LB: busy_line high 2 cycles, result after 3 edges.

Test Plan:
- Pass-through:
  - Stimulus: ALU op (opcode_in[6:0] = 7'b0110011), data_in = 0x1234_5678, Rd_in = 5.
  - Response: next edge outputs = same values; busy_line and mem_req never high.
- LW with immediate acks:
  - Stimulus: address 0x100; memory bytes 0x78, 0x56, 0x34, 0x12.
  - Response: mem_addr sequence 0x100–0x103; busy_line high 5 cycles; data_out = 0x1234_5678, Rd_out correct; bubble outputs before the result.
- LB/LBU/LH/LHU extension:
  - Stimulus: bytes 0x80, 0xFF.
  - Response: LB → 0xFFFF_FF80; LBU → 0x0000_0080; LH → 0xFFFF_FF80; LHU → 0x0000_FF80.
- SW with 3-cycle ack latency per byte:
  - Stimulus: address 0x200, scrdata_in = 0xAABB_CCDD.
  - Response: writes DD, CC, BB, AA to 0x200–0x203, mem_we = 1 throughout; mem_req held continuously; busy_line high 13 cycles.
- Address wrap:
  - Stimulus: SH at 0xFFFF_FFFF.
  - Response: bytes go to 0xFFFF_FFFF then 0x0000_0000.
- Reset mid-access:
  - Stimulus: assert rst after the 2nd ack of an LW.
  - Response: next edge state IDLE, all outputs 0, mem_req low; a subsequent ALU op passes through normally; a stray ack is ignored.
